// File: rtl/spi_master_pkg.sv
// Shared definitions for spi_master: register offsets, STATUS bit indices,
// CTRL field positions and the transfer FSM state type.
package spi_master_pkg;

  // Word offsets, decoded from iomem_addr[3:2]
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegRsvd   = 2'd3;

  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatTxEmpty = 1;
  localparam int unsigned StatTxFull  = 2;
  localparam int unsigned StatRxv     = 3;
  localparam int unsigned StatOvf     = 4;

  // CTRL: divider occupies [DIV_W-1:0], chip-select force is a single bit
  localparam int unsigned CtrlCsForce = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous byte FIFO for the SPI transmit path; Depth must be a power of two.
// The caller only pushes when not full (or when popping in the same cycle) and only pops when not empty.
module spi_tx_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [7:0]  mem_q [Depth];
  logic [Aw:0] wr_ptr_q, rd_ptr_q;

  // Extra pointer bit tells full from empty when the indices match
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) &&
                   (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (Aw+1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (Aw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI mode-0 master for picosoc (DATA/STATUS/CTRL registers).
// Build with SPI_MASTER_FIFO_EN to get a FIFO_DEPTH-entry TX FIFO instead of a single holding register.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso
);

  spi_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, ctrl_div_q;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_byte_q;
  logic             sck_q, sck_d, mosi_q, mosi_d;
  logic             cs_force_q, ovf_q, rxv_q, ready_q;
  logic [31:0]      rdata_q, rd_val;
  logic             busy, load, rx_done;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_rdata;
  logic             access, wr_en, rd_en, push_req;
  logic [1:0]       reg_sel;
  logic             unused_bits;

  assign reg_sel  = iomem_addr[3:2];
  assign access   = iomem_valid & ~ready_q;
  assign wr_en    = access & (iomem_wstrb != 4'b0);
  assign rd_en    = access & (iomem_wstrb == 4'b0);
  assign push_req = wr_en & (reg_sel == RegData) & iomem_wstrb[0];
  // A pop in the same cycle frees the slot, so a push into a full TX still lands
  assign tx_push  = push_req & (~tx_full | tx_pop);
  assign busy     = (state_q != StIdle);

  assign unused_bits = ^{iomem_addr, iomem_wdata, iomem_wstrb, FIFO_DEPTH};

`ifdef SPI_MASTER_FIFO_EN
  spi_tx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (tx_push),
    .wdata_i (iomem_wdata[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );
`else
  logic       tx_valid_q;
  logic [7:0] tx_data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if (tx_push) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= iomem_wdata[7:0];
    end else if (tx_pop) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_rdata = tx_data_q;
  assign tx_full  = tx_valid_q;
  assign tx_empty = ~tx_valid_q;
`endif

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      RegData:   rd_val[7:0] = rx_byte_q;
      RegStatus: begin
        rd_val[StatOvf]     = ovf_q;
        rd_val[StatRxv]     = rxv_q;
        rd_val[StatTxFull]  = tx_full;
        rd_val[StatTxEmpty] = tx_empty;
        rd_val[StatBusy]    = busy;
      end
      RegCtrl: begin
        rd_val[DIV_W-1:0]  = ctrl_div_q;
        rd_val[CtrlCsForce] = cs_force_q;
      end
      RegRsvd:   rd_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    div_d   = div_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    tx_pop  = 1'b0;
    rx_done = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: if (!tx_empty) state_d = StLoad;
      StLoad: load = 1'b1;
      StShiftLo: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], spi_miso};
          state_d = StShiftHi;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StShiftHi: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            mosi_d  = tx_sr_q[6];
            state_d = StShiftLo;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StDone: begin
        rx_done = 1'b1;
        // Back-to-back: DONE performs the next byte's load so SCK stays low only one cycle
        if (!tx_empty) load = 1'b1;
        else           state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      tx_pop  = 1'b1;
      tx_sr_d = tx_rdata;
      mosi_d  = tx_rdata[7];
      div_d   = ctrl_div_q;
      cnt_d   = '0;
      bit_d   = '0;
      state_d = StShiftLo;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_byte_q  <= '0;
      ctrl_div_q <= '0;
      cs_force_q <= 1'b0;
      ovf_q      <= 1'b0;
      rxv_q      <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      ready_q <= access;
      rdata_q <= rd_en ? rd_val : '0;
      if (wr_en && reg_sel == RegCtrl) begin
        ctrl_div_q <= iomem_wdata[DIV_W-1:0];
        cs_force_q <= iomem_wdata[CtrlCsForce];
      end
      if (push_req && tx_full && !tx_pop) begin
        ovf_q <= 1'b1;
      end else if (wr_en && reg_sel == RegStatus && iomem_wstrb[0] && iomem_wdata[StatOvf]) begin
        ovf_q <= 1'b0;
      end
      // A completing byte outranks a DATA read clearing RXV in the same cycle
      if (rx_done) begin
        rx_byte_q <= rx_sr_q;
        rxv_q     <= 1'b1;
      end else if (rd_en && reg_sel == RegData) begin
        rxv_q <= 1'b0;
      end
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs_n    = ~(cs_force_q | busy);

endmodule
